// File: rtl/qoa_pkg.sv
// Shared definitions for the multi-channel QOA LMS decoder: opcode fields,
// FSM states, shift defaults, int16 limits and small helper functions.
package qoa_pkg;

    localparam int FRAC_SHIFT_DEF  = 13;
    localparam int DELTA_SHIFT_DEF = 4;

    // Command byte layout
    localparam int OP_DECODE_BIT = 0;
    localparam int OP_HI_BIT     = 7;
    localparam int LOAD_SEL_BIT  = 1;
    localparam int LOAD_IDX_LSB  = 2;
    localparam int CH_LSB        = 2;

    localparam logic [7:0] OP_CLASS_MASK = 8'hC0;
    localparam logic [7:0] OP_READ       = 8'h80;
    localparam logic [7:0] OP_SELECT     = 8'hC0;

    localparam logic signed [15:0] INT16_MIN = 16'sh8000;
    localparam logic signed [15:0] INT16_MAX = 16'sh7FFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        MAC,
        UPDATE,
        READ_SKIP
    } state_t;

    function automatic logic signed [15:0] clamp16(input logic signed [31:0] v);
        if (v > 32'(INT16_MAX)) return INT16_MAX;
        if (v < 32'(INT16_MIN)) return INT16_MIN;
        return v[15:0];
    endfunction

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qoa_lms_bank.sv
// Per-channel LMS storage: four history and four weight words per channel,
// with an indexed read tap, a word load port and the post-decode update.
module qoa_lms_bank #(
    parameter int NUM_CH = 2,
    parameter int CW     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW-1:0]       ch,
    input  logic [1:0]          rd_idx,
    output logic signed [15:0]  rd_hist,
    output logic signed [15:0]  rd_wt,
    output logic signed [15:0]  last_sample,
    input  logic                load_en,
    input  logic                load_sel,
    input  logic [1:0]          load_idx,
    input  logic [15:0]         load_data,
    input  logic                upd_en,
    input  logic signed [15:0]  upd_sample,
    input  logic signed [15:0]  upd_delta
);

    logic signed [15:0] hist [NUM_CH][4];
    logic signed [15:0] wt   [NUM_CH][4];

    assign rd_hist     = hist[ch][rd_idx];
    assign rd_wt       = wt[ch][rd_idx];
    assign last_sample = hist[ch][3];

    // Weight updates read the pre-shift history thanks to non-blocking semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < 4; i++) begin
                    hist[c][i] <= '0;
                    wt[c][i]   <= '0;
                end
            end
        end else if (upd_en) begin
            for (int i = 0; i < 4; i++) begin
                wt[ch][i] <= wt[ch][i] + (hist[ch][i][15] ? -upd_delta : upd_delta);
            end
            hist[ch][0] <= hist[ch][1];
            hist[ch][1] <= hist[ch][2];
            hist[ch][2] <= hist[ch][3];
            hist[ch][3] <= upd_sample;
        end else if (load_en) begin
            if (load_sel) wt[ch][load_idx]   <= load_data;
            else          hist[ch][load_idx] <= load_data;
        end
    end

endmodule

// File: rtl/qoa_rom.sv
// QOA dequantisation ROM: scalefactor index sf and quantised residual qr
// map to the signed dequantised residual (round(scale * {0.75,2.5,4.5,7})).
module qoa_rom (
    input  logic [3:0]         sf,
    input  logic [2:0]         qr,
    output logic signed [15:0] dequant
);

    logic [11:0] scale;
    logic [4:0]  mult4;
    logic [16:0] scaled;
    logic signed [15:0] mag;

    always_comb begin
        scale = 12'd1;
        case (sf)
            4'd0:  scale = 12'd1;
            4'd1:  scale = 12'd7;
            4'd2:  scale = 12'd21;
            4'd3:  scale = 12'd45;
            4'd4:  scale = 12'd84;
            4'd5:  scale = 12'd138;
            4'd6:  scale = 12'd211;
            4'd7:  scale = 12'd304;
            4'd8:  scale = 12'd421;
            4'd9:  scale = 12'd562;
            4'd10: scale = 12'd731;
            4'd11: scale = 12'd928;
            4'd12: scale = 12'd1157;
            4'd13: scale = 12'd1419;
            4'd14: scale = 12'd1715;
            default: scale = 12'd2048;
        endcase
    end

    // Multipliers held as 4x values so the +2 and >>2 give round-half-up.
    always_comb begin
        mult4 = 5'd3;
        case (qr[2:1])
            2'd0:    mult4 = 5'd3;
            2'd1:    mult4 = 5'd10;
            2'd2:    mult4 = 5'd18;
            default: mult4 = 5'd28;
        endcase
    end

    assign scaled  = 17'(scale) * 17'(mult4) + 17'd2;
    assign mag     = {1'b0, scaled[16:2]};
    assign dequant = qr[0] ? -mag : mag;

endmodule

// File: rtl/qoa_lms_decoder_mc.sv
// Multi-channel QOA LMS sample decoder driven by SPI command bytes.
// Build macro QOA_AUTO_CH_ADV_EN: advance the active channel after every decode.
module qoa_lms_decoder_mc
    import qoa_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int FRAC_SHIFT  = FRAC_SHIFT_DEF,
    parameter int DELTA_SHIFT = DELTA_SHIFT_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [3:0]  sample_ch,
    output logic [15:0] tx_word
);

    localparam int         CW       = ch_bits(NUM_CH);
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);
`ifdef QOA_AUTO_CH_ADV_EN
    localparam bit         AUTO_ADV = 1'b1;
`else
    localparam bit         AUTO_ADV = 1'b0;
`endif
    localparam logic [3:0] LAST_CH  = 4'(NUM_CH - 1);

    state_t state, next_state;

    logic [3:0]         ch;
    logic [3:0]         sel_ch;
    logic signed [15:0] dequant, rom_out, delta;
    logic signed [15:0] rd_hist, rd_wt, last_sample, sample_next;
    logic signed [31:0] acc, prod, pred, sum;
    logic [1:0]         tap, load_idx;
    logic [7:0]         hi_byte;
    logic               load_sel, skip_second;
    logic               is_decode, is_load, is_read, load_en, upd_en;

    assign is_decode = in_byte[OP_DECODE_BIT];
    assign is_load   = !is_decode && !in_byte[OP_HI_BIT];
    assign is_read   = !is_decode && ((in_byte & OP_CLASS_MASK) == OP_READ);
    assign sel_ch    = in_byte[CH_LSB +: 4];

    // in_valid is a one-cycle strobe with no back-pressure: a byte that
    // arrives while busy is high is discarded and latches overrun.
    assign busy = (state == MAC) || (state == UPDATE);

    assign prod        = 32'(rd_hist) * 32'(rd_wt);
    assign pred        = acc >>> FRAC_SHIFT;
    assign sum         = pred + 32'(dequant);
    assign sample_next = clamp16(sum);
    assign delta       = dequant >>> DELTA_SHIFT;

    qoa_rom u_rom (
        .sf      (in_byte[7:4]),
        .qr      (in_byte[3:1]),
        .dequant (rom_out)
    );

    qoa_lms_bank #(.NUM_CH(NUM_CH), .CW(CW)) u_bank (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .ch          (ch[CW-1:0]),
        .rd_idx      (tap),
        .rd_hist     (rd_hist),
        .rd_wt       (rd_wt),
        .last_sample (last_sample),
        .load_en     (load_en),
        .load_sel    (load_sel),
        .load_idx    (load_idx),
        .load_data   ({hi_byte, in_byte}),
        .upd_en      (upd_en),
        .upd_sample  (sample_next),
        .upd_delta   (delta)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        upd_en     = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                if (is_decode)    next_state = MAC;
                else if (is_load) next_state = LOAD_HI;
                else if (is_read) next_state = READ_SKIP;
            end
            LOAD_HI:   if (in_valid) next_state = LOAD_LO;
            LOAD_LO:   if (in_valid) begin
                next_state = IDLE;
                load_en    = 1'b1;
            end
            MAC:       if (tap == 2'd3) next_state = UPDATE;
            UPDATE: begin
                next_state = IDLE;
                upd_en     = 1'b1;
            end
            READ_SKIP: if (in_valid && skip_second) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ch           <= '0;
            dequant      <= '0;
            acc          <= '0;
            tap          <= '0;
            hi_byte      <= '0;
            load_sel     <= 1'b0;
            load_idx     <= '0;
            skip_second  <= 1'b0;
            overrun      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            tx_word      <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (in_valid && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    if (is_decode) begin
                        dequant <= rom_out;
                        acc     <= '0;
                        tap     <= '0;
                    end else if (is_load) begin
                        load_sel <= in_byte[LOAD_SEL_BIT];
                        load_idx <= in_byte[LOAD_IDX_LSB +: 2];
                    end else if (is_read) begin
                        tx_word     <= last_sample;
                        skip_second <= 1'b0;
                    end else if ({1'b0, sel_ch} < NUM_CH_W) begin
                        ch <= sel_ch;
                    end
                end
                LOAD_HI:   if (in_valid) hi_byte <= in_byte;
                READ_SKIP: if (in_valid) skip_second <= 1'b1;
                MAC: begin
                    acc <= acc + prod;
                    tap <= tap + 2'd1;
                end
                UPDATE: begin
                    sample_out   <= sample_next;
                    sample_ch    <= ch;
                    sample_valid <= 1'b1;
                    acc          <= '0;
                    if (AUTO_ADV) ch <= (ch == LAST_CH) ? 4'd0 : ch + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qoa_lms_decoder_mc.sv
// Bench for qoa_lms_decoder_mc: directed scenarios plus random command traffic,
// all checked every cycle against a transaction-level model of the decoder.
module tb_qoa_lms_decoder_mc;

    localparam int NUM_CH = 2;
    localparam int M_IDLE = 0, M_LOAD_HI = 1, M_LOAD_LO = 2, M_SKIP = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        busy, overrun, sample_valid;
    logic [15:0] sample_out, tx_word;
    logic [3:0]  sample_ch;

    qoa_lms_decoder_mc #(.NUM_CH(NUM_CH)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .busy         (busy),
        .overrun      (overrun),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .tx_word      (tx_word)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int  scale_tab [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    real mult_tab  [4]  = '{0.75, 2.5, 4.5, 7.0};
    shortint mh [16][4];
    shortint mw [16][4];
    int          m_ch, m_mode, m_skip, m_idx, m_dec_n;
    logic        m_sel, m_ovr;
    logic [7:0]  m_hi;
    logic [15:0] m_tx, m_out;
    logic [3:0]  m_out_ch;
    logic [15:0] exp_q[$];
    logic [3:0]  exp_ch_q[$];
    int          exp_cyc_q[$];
    logic        cmp_v, cmp_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_dq(input int sf, input int qr);
        int mag;
        mag = $rtoi(real'(scale_tab[sf]) * mult_tab[qr / 2] + 0.5);
        return (qr % 2 == 1) ? -mag : mag;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 16; c++)
            for (int i = 0; i < 4; i++) begin
                mh[c][i] = 0;
                mw[c][i] = 0;
            end
        m_ch = 0; m_mode = M_IDLE; m_skip = 0; m_idx = 0; m_sel = 1'b0;
        m_hi = '0; m_ovr = 1'b0; m_tx = '0; m_out = '0; m_out_ch = '0;
        m_dec_n = -100;
        exp_q.delete(); exp_ch_q.delete(); exp_cyc_q.delete();
    endfunction

    function automatic void model_decode(input logic [7:0] b, input int n);
        int dq, acc, pred, s, delta;
        dq  = model_dq(int'(b[7:4]), int'(b[3:1]));
        acc = 0;
        for (int i = 0; i < 4; i++) acc += int'(mh[m_ch][i]) * int'(mw[m_ch][i]);
        pred = acc >>> 13;
        s = pred + dq;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        delta = dq >>> 4;
        for (int i = 0; i < 4; i++)
            mw[m_ch][i] = shortint'(int'(mw[m_ch][i]) + ((mh[m_ch][i] < 0) ? -delta : delta));
        for (int i = 0; i < 3; i++) mh[m_ch][i] = mh[m_ch][i + 1];
        mh[m_ch][3] = shortint'(s);
        exp_q.push_back(16'(s));
        exp_ch_q.push_back(4'(m_ch));
        exp_cyc_q.push_back(n + 5);
        m_dec_n = n;
`ifdef QOA_AUTO_CH_ADV_EN
        m_ch = (m_ch + 1) % NUM_CH;
`endif
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int n);
        logic [15:0] data;
        if (m_dec_n >= 0 && n > m_dec_n && n <= m_dec_n + 5) begin
            m_ovr = 1'b1;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (b[0]) model_decode(b, n);
                else if (!b[7]) begin
                    m_sel = b[1]; m_idx = int'(b[3:2]); m_mode = M_LOAD_HI;
                end else if (!b[6]) begin
                    m_tx = 16'(mh[m_ch][3]); m_skip = 2; m_mode = M_SKIP;
                end else if (int'(b[5:2]) < NUM_CH) begin
                    m_ch = int'(b[5:2]);
                end
            end
            M_LOAD_HI: begin
                m_hi = b; m_mode = M_LOAD_LO;
            end
            M_LOAD_LO: begin
                data = {m_hi, b};
                if (m_sel) mw[m_ch][m_idx] = shortint'(data);
                else       mh[m_ch][m_idx] = shortint'(data);
                m_mode = M_IDLE;
            end
            default: begin
                m_skip--;
                if (m_skip == 0) m_mode = M_IDLE;
            end
        endcase
    endfunction

    // Model follows the bench-driven inputs at every active edge.
    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            model_reset();
            chk_on = 1'b1;
        end else if (in_valid) begin
            model_byte(in_byte, cyc);
        end
    end

    always @(negedge sys_clk) begin
        if (chk_on) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                void'(exp_q.pop_front());
                void'(exp_ch_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            cmp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            if (cmp_v) begin
                m_out    = exp_q.pop_front();
                m_out_ch = exp_ch_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            cmp_busy = (m_dec_n >= 0) && (cyc >= m_dec_n) && (cyc <= m_dec_n + 4);
            check("sample_valid", sample_valid, cmp_v);
            check("sample_out", sample_out, m_out);
            check("sample_ch", sample_ch, m_out_ch);
            check("busy", busy, cmp_busy);
            check("overrun", overrun, m_ovr);
            check("tx_word", tx_word, m_tx);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        in_valid = 1'b0;
        sys_rst  = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic decode_and_wait(input logic [7:0] b);
        send(b);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    int r;
    logic [3:0] ch_seq [3];

    initial begin
        in_valid = 1'b0;
        in_byte  = '0;
        sys_rst  = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        check("rom_sf0_qr0", model_dq(0, 0), 32'd1);
        check("rom_sf1_qr2", model_dq(1, 2), 32'd18);
        check("rom_sf15_qr7", model_dq(15, 7), -32'sd14336);

        @(negedge sys_clk);
        check("reset_busy", busy, 0);
        check("reset_sample_out", sample_out, 0);
        check("reset_tx_word", tx_word, 0);
        check("reset_overrun", overrun, 0);

        // First decode from cleared state gives the ROM value itself
        decode_and_wait(8'h01);
        check("t1_valid", sample_valid, 1);
        check("t1_sample", sample_out, 16'h0001);
        check("t1_ch", sample_ch, 0);
        check("t1_model_h3", 16'(mh[0][3]), 16'h0001);

        // Loaded history/weight drive prediction past int16 range
        send(8'hC0);
        send(8'h0C); send(8'h7F); send(8'hFF);
        send(8'h0E); send(8'h40); send(8'h00);
        decode_and_wait(8'h01);
        check("t2_clamped", sample_out, 16'h7FFF);

        // Channel isolation and read-back
        send(8'hC4);
        decode_and_wait(8'h01);
        check("t3_ch1_sample", sample_out, 16'h0001);
        check("t3_ch1_id", sample_ch, 1);
        send(8'hC0);
        send(8'h80);
        @(negedge sys_clk);
        check("t3_tx_word", tx_word, 16'h7FFF);
        send(8'h01);
        send(8'h01);
        repeat (2) @(posedge sys_clk);

        // Byte during busy is dropped
        @(negedge sys_clk);
        check("t4_overrun_before", overrun, 0);
        send(8'h01);
        repeat (1) @(posedge sys_clk);
        send(8'h55);
        repeat (8) @(posedge sys_clk);
        @(negedge sys_clk);
        check("t4_overrun_after", overrun, 1);

        // Reset mid-decode
        send(8'h01);
        repeat (2) @(posedge sys_clk);
        pulse_reset();
        @(negedge sys_clk);
        check("t5_busy", busy, 0);
        check("t5_valid", sample_valid, 0);
        check("t5_overrun", overrun, 0);
        repeat (8) @(posedge sys_clk);
        decode_and_wait(8'h01);
        check("t5_cleared_bank", sample_out, 16'h0001);

        // Channel sequence over three decodes
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            decode_and_wait(8'h01);
            ch_seq[k] = sample_ch;
            repeat (1) @(posedge sys_clk);
        end
`ifdef QOA_AUTO_CH_ADV_EN
        check("t6_seq0", ch_seq[0], 0);
        check("t6_seq1", ch_seq[1], 1);
        check("t6_seq2", ch_seq[2], 0);
`else
        check("t6_seq0", ch_seq[0], 0);
        check("t6_seq1", ch_seq[1], 0);
        check("t6_seq2", ch_seq[2], 0);
`endif

        // Random command traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 39);
            if (r < 16) begin
                send({4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1});
            end else if (r < 22) begin
                send({1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'b0});
                send(8'($urandom));
                send(8'($urandom));
            end else if (r < 26) begin
                send({2'b10, 5'($urandom_range(0, 31)), 1'b0});
                send(8'($urandom));
                send(8'($urandom));
            end else if (r < 31) begin
                send({2'b11, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0});
            end else if (r < 39) begin
                send(8'($urandom));
            end else begin
                pulse_reset();
            end
            repeat ($urandom_range(0, 7)) @(posedge sys_clk);
        end

        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        check("pending_samples", exp_cyc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
